// File: rtl/req_pkg.sv
// Shared constants and the index-width helper for the request capture
// stage that feeds the 8-to-3 priority encoder.
package req_pkg;

  localparam int REQ_WIDTH = 8;
  localparam int REQ_IDX_W = 3;

  // Never returns less than 1 so a one-line build still has a legal clr_idx port.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// One request line: multi-flop synchronizer, last-value flop and event detect.
module sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // prev resets low, so a line held high through reset yields one edge event.
  assign rise = EDGE_MODE ? (sync_q[SYNC_STAGES-1] & ~prev_q) : sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/request_latch8.sv
// Sticky per-line request capture with indexed clear; presents masked pending
// bits and an "any pending" enable to the priority encoder.
module request_latch8
  import req_pkg::*;
#(
  parameter int WIDTH       = REQ_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b1,
  localparam int IDX_W      = (WIDTH == REQ_WIDTH) ? REQ_IDX_W : clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req_in,
  input  logic [WIDTH-1:0] mask,
  input  logic             clr_valid,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic             clr_all,
  output logic [WIDTH-1:0] pend,
  output logic             en,
  output logic [WIDTH-1:0] overflow
);

  logic [WIDTH-1:0] rise, set, clr_vec;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] overflow_q, overflow_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             en_q, en_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_line
    sync_edge #(
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE_MODE  (EDGE_MODE)
    ) u_sync_edge (
      .clk (clk),
      .rst (rst),
      .d_in(req_in[i]),
      .rise(rise[i])
    );
  end

  always_comb begin
    set = rise & ~mask;
    clr_vec = '0;
    if (clr_all) begin
      clr_vec = '1;
    end else if (clr_valid) begin
      clr_vec = {{(WIDTH-1){1'b0}}, 1'b1} << clr_idx;
    end
    // Set is OR'd in after the clear so a same-cycle event is never lost.
    pending_d  = (pending_q & ~clr_vec) | set;
    overflow_d = (clr_all ? '0 : overflow_q) | (set & pending_q & ~clr_vec);
    pend_d     = pending_d & ~mask;
    en_d       = |pend_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      overflow_q <= '0;
      pend_q     <= '0;
      en_q       <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      pend_q     <= pend_d;
      en_q       <= en_d;
    end
  end

  assign pend     = pend_q;
  assign en       = en_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_request_latch8.sv
// Directed bench for request_latch8: edge-mode and level-mode instances on shared stimulus.
module tb_request_latch8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic       clr_valid;
  logic [2:0] clr_idx;
  logic       clr_all;

  logic [7:0] pend_e, ovf_e, pend_l, ovf_l;
  logic       en_e, en_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  request_latch8 #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_MODE(1'b1)) u_edge (
    .clk(clk), .rst(rst), .req_in(req_in), .mask(mask), .clr_valid(clr_valid),
    .clr_idx(clr_idx), .clr_all(clr_all), .pend(pend_e), .en(en_e), .overflow(ovf_e)
  );

  request_latch8 #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_MODE(1'b0)) u_lvl (
    .clk(clk), .rst(rst), .req_in(req_in), .mask(mask), .clr_valid(clr_valid),
    .clr_idx(clr_idx), .clr_all(clr_all), .pend(pend_l), .en(en_l), .overflow(ovf_l)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Pulse the given lines for one sampled edge, then wait until the event is presented.
  task automatic pulse(input logic [7:0] lines);
    req_in = lines;
    tick();
    req_in = 8'h00;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; req_in = 8'h00; mask = 8'h00;
    clr_valid = 1'b0; clr_idx = 3'd0; clr_all = 1'b0;
    tick();
    tick();
    check("reset_pend", pend_e, 8'h00);
    check("reset_en", {7'd0, en_e}, 8'h00);
    check("reset_ovf", ovf_e, 8'h00);

    // Single pulse on line 2: presented exactly 3 edges after the rise.
    rst = 1'b0;
    tick();
    req_in = 8'b0000_0100;
    tick();
    req_in = 8'h00;
    tick();
    check("lat_edge2_pend", pend_e, 8'h00);
    tick();
    check("lat_edge3_pend", pend_e, 8'b0000_0100);
    check("lat_edge3_en", {7'd0, en_e}, 8'h01);
    clr_valid = 1'b1; clr_idx = 3'd2;
    tick();
    clr_valid = 1'b0;
    check("clr2_pend", pend_e, 8'h00);
    check("clr2_en", {7'd0, en_e}, 8'h00);

    // Lines 7 and 0 together, clear 7 only.
    pulse(8'b1000_0001);
    check("two_pend", pend_e, 8'b1000_0001);
    clr_valid = 1'b1; clr_idx = 3'd7;
    tick();
    clr_valid = 1'b0;
    check("clr7_pend", pend_e, 8'b0000_0001);
    check("clr7_en", {7'd0, en_e}, 8'h01);
    clr_valid = 1'b1; clr_idx = 3'd0;
    tick();
    clr_valid = 1'b0;
    check("clr0_pend", pend_e, 8'h00);

    // Line 3 twice without a clear: overflow, then clr_all wipes both.
    pulse(8'b0000_1000);
    check("ovf_first_ovf", ovf_e, 8'h00);
    pulse(8'b0000_1000);
    check("ovf_pend", pend_e, 8'b0000_1000);
    check("ovf_flag", ovf_e, 8'b0000_1000);
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    check("clrall_pend", pend_e, 8'h00);
    check("clrall_ovf", ovf_e, 8'h00);

    // Line 5 pending, second event lands on the same edge as clear of index 5.
    pulse(8'b0010_0000);
    check("same_pre_pend", pend_e, 8'b0010_0000);
    req_in = 8'b0010_0000;
    tick();
    req_in = 8'h00;
    tick();
    clr_valid = 1'b1; clr_idx = 3'd5;
    tick();
    clr_valid = 1'b0;
    check("same_pend", pend_e, 8'b0010_0000);
    check("same_ovf", ovf_e, 8'h00);
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;

    // Fully masked event is discarded, not deferred.
    mask = 8'hFF;
    pulse(8'b0000_0010);
    check("mask_pend", pend_e, 8'h00);
    check("mask_en", {7'd0, en_e}, 8'h00);
    mask = 8'h00;
    tick();
    check("unmask_discard", pend_e, 8'h00);

    // Mask hides a pending bit; unmasking re-presents it.
    pulse(8'b0100_0000);
    check("l6_pend", pend_e, 8'b0100_0000);
    mask = 8'b0100_0000;
    tick();
    check("l6_masked_pend", pend_e, 8'h00);
    check("l6_masked_en", {7'd0, en_e}, 8'h00);
    mask = 8'h00;
    tick();
    check("l6_unmask_pend", pend_e, 8'b0100_0000);
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;

    // Line 4 held high across reset release, both modes.
    req_in = 8'b0001_0000;
    rst = 1'b1;
    tick();
    tick();
    check("hold_rst_pend_e", pend_e, 8'h00);
    check("hold_rst_pend_l", pend_l, 8'h00);
    rst = 1'b0;
    tick();
    tick();
    tick();
    check("hold_pend_e", pend_e, 8'b0001_0000);
    check("hold_pend_l", pend_l, 8'b0001_0000);
    clr_valid = 1'b1; clr_idx = 3'd4;
    tick();
    clr_valid = 1'b0;
    check("hold_clr_pend_e", pend_e, 8'h00);
    check("hold_clr_pend_l", pend_l, 8'b0001_0000);
    tick();
    tick();
    check("hold_later_pend_e", pend_e, 8'h00);
    check("hold_later_pend_l", pend_l, 8'b0001_0000);
    check("hold_later_en_l", {7'd0, en_l}, 8'h01);

    // Reset mid-operation with an overflow outstanding.
    req_in = 8'h00;
    tick();
    pulse(8'b0000_1000);
    pulse(8'b0000_1000);
    check("mid_pre_pend", pend_e, 8'b0000_1000);
    check("mid_pre_ovf", ovf_e, 8'b0000_1000);
    rst = 1'b1;
    tick();
    check("mid_rst_pend", pend_e, 8'h00);
    check("mid_rst_en", {7'd0, en_e}, 8'h00);
    check("mid_rst_ovf", ovf_e, 8'h00);
    check("mid_rst_pend_l", pend_l, 8'h00);
    check("mid_rst_ovf_l", ovf_l, 8'h00);
    rst = 1'b0;
    tick();
    tick();
    check("mid_after_pend", pend_e, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
